// File: rtl/mem_timing_seq.sv
// Core-memory access timing sequencer: bit-time windows, run/halt gating, module select and duplex failover.
// Optional single repeat of a simplex access on parity error when MEM_TIMING_RETRY_EN is defined.
module mem_timing_seq #(
    parameter int NUM_MODULES = 4,
    parameter int CYCLE_LEN   = 14,
    parameter int STROBE_BT   = 5
) (
    input  logic                           CLK,
    input  logic                           RSTN,
    input  logic                           START,
    input  logic                           WR,
    input  logic [$clog2(NUM_MODULES)-1:0] MSEL,
    input  logic                           DUPLEX,
    input  logic                           HALT,
    input  logic [NUM_MODULES-1:0]         ERRP,
    output logic                           RUN,
    output logic                           BUSY,
    output logic                           SYNC,
    output logic                           RD,
    output logic                           SINK,
    output logic                           TIME,
    output logic                           RDM,
    output logic                           INHBS,
    output logic                           DONE,
    output logic [NUM_MODULES-1:0]         MEN,
    output logic [NUM_MODULES-1:0]         DSEL,
`ifdef MEM_TIMING_RETRY_EN
    output logic                           RETRY,
`endif
    output logic                           ERRF
);

    localparam int HALF = CYCLE_LEN / 2;
    localparam int MW   = $clog2(NUM_MODULES);
    localparam int BTW  = $clog2(CYCLE_LEN);

    localparam logic [BTW-1:0] BT_ZERO     = BTW'(0);
    localparam logic [BTW-1:0] BT_ONE      = BTW'(1);
    localparam logic [BTW-1:0] BT_HALF     = BTW'(HALF);
    localparam logic [BTW-1:0] BT_SINK_END = BTW'(HALF - 2);
    localparam logic [BTW-1:0] BT_STRB     = BTW'(STROBE_BT);
    localparam logic [BTW-1:0] BT_RDM      = BTW'(STROBE_BT + 1);
    localparam logic [BTW-1:0] BT_LAST     = BTW'(CYCLE_LEN - 1);
    localparam logic [MW-1:0]  MSEL_PAIR   = MW'(1);

    function automatic logic [NUM_MODULES-1:0] f_onehot(input logic [MW-1:0] sel);
        logic [NUM_MODULES-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    function automatic logic [NUM_MODULES-1:0] f_pair(input logic [MW-1:0] sel);
        return f_onehot(sel) | f_onehot(sel ^ MSEL_PAIR);
    endfunction

    logic                   r_busy, r_wr, r_dup, r_run, r_errf;
    logic [BTW-1:0]         r_bt;
    logic [MW-1:0]          r_msel;
    logic                   r_sync, r_rd, r_sink, r_time, r_rdm, r_inhbs, r_done;
    logic [NUM_MODULES-1:0] r_men, r_dsel;

    logic                   w_busy, w_wr, w_dup, w_run, w_errf;
    logic [BTW-1:0]         w_bt;
    logic [MW-1:0]          w_msel, w_part;
    logic [NUM_MODULES-1:0] w_men, w_dsel;
    logic                   w_last, w_chk, w_fail_self, w_fail_part;
    logic                   w_set_errf, w_switch, w_retry_go;

`ifdef MEM_TIMING_RETRY_EN
    logic r_rpend, r_retry, w_rpend, w_retry, w_set_rpend;
    assign w_retry_go = w_last && r_rpend;
`else
    assign w_retry_go = 1'b0;
`endif

    assign w_last      = r_busy && (r_bt == BT_LAST);
    assign w_chk       = r_busy && (r_bt == BT_STRB);
    assign w_part      = r_msel ^ MSEL_PAIR;
    assign w_fail_self = ERRP[r_msel];
    assign w_fail_part = ERRP[w_part];

    // Parity evaluation at the edge that closes the sense-strobe bit time
    always_comb begin
        w_set_errf = 1'b0;
        w_switch   = 1'b0;
`ifdef MEM_TIMING_RETRY_EN
        w_set_rpend = 1'b0;
`endif
        if (w_chk && !r_dup) begin
`ifdef MEM_TIMING_RETRY_EN
            w_set_errf  = w_fail_self && r_retry;
            w_set_rpend = w_fail_self && !r_retry;
`else
            w_set_errf = w_fail_self;
`endif
        end else if (w_chk) begin
            w_set_errf = w_fail_self && w_fail_part;
            w_switch   = w_fail_self && !w_fail_part;
        end else begin
            w_set_errf = 1'b0;
            w_switch   = 1'b0;
        end
    end

    // Next-state sequencing: accept, bit-time advance, retry/back-to-back restart, completion
    always_comb begin
        w_busy = r_busy;
        w_bt   = r_bt;
        w_wr   = r_wr;
        w_msel = r_msel;
        w_dup  = r_dup;
        w_dsel = r_dsel;
        w_errf = r_errf | w_set_errf;
`ifdef MEM_TIMING_RETRY_EN
        w_retry = r_retry;
        w_rpend = r_rpend | w_set_rpend;
`endif
        if (!r_busy) begin
            if (START && r_run) begin
                w_busy = 1'b1;
                w_bt   = BT_ZERO;
                w_wr   = WR;
                w_msel = MSEL;
                w_dup  = DUPLEX;
                w_dsel = f_onehot(MSEL);
            end else begin
                w_busy = 1'b0;
                w_dsel = '0;
            end
        end else if (!w_last) begin
            w_bt   = r_bt + BT_ONE;
            w_dsel = w_switch ? f_onehot(w_part) : r_dsel;
        end else if (w_retry_go) begin
            w_bt   = BT_ZERO;
            w_dsel = f_onehot(r_msel);
`ifdef MEM_TIMING_RETRY_EN
            w_retry = 1'b1;
            w_rpend = 1'b0;
`endif
        end else if (START && r_run && !HALT) begin
            w_bt   = BT_ZERO;
            w_wr   = WR;
            w_msel = MSEL;
            w_dup  = DUPLEX;
            w_dsel = f_onehot(MSEL);
`ifdef MEM_TIMING_RETRY_EN
            w_retry = 1'b0;
`endif
        end else begin
            w_busy = 1'b0;
            w_dsel = '0;
`ifdef MEM_TIMING_RETRY_EN
            w_retry = 1'b0;
`endif
        end

        // A halt seen mid-access only takes effect once the access (and any repeat) has finished
        if (!HALT) begin
            w_run = 1'b1;
        end else if (!r_busy) begin
            w_run = 1'b0;
        end else if (w_last && !w_retry_go) begin
            w_run = 1'b0;
        end else begin
            w_run = r_run;
        end

        w_men = w_busy ? (w_dup ? f_pair(w_msel) : f_onehot(w_msel)) : '0;
    end

    // State and registered output decode from next-state values
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_busy  <= 1'b0;
            r_bt    <= BT_ZERO;
            r_wr    <= 1'b0;
            r_msel  <= '0;
            r_dup   <= 1'b0;
            r_run   <= 1'b1;
            r_errf  <= 1'b0;
            r_sync  <= 1'b0;
            r_rd    <= 1'b0;
            r_sink  <= 1'b0;
            r_time  <= 1'b0;
            r_rdm   <= 1'b0;
            r_inhbs <= 1'b0;
            r_done  <= 1'b0;
            r_men   <= '0;
            r_dsel  <= '0;
`ifdef MEM_TIMING_RETRY_EN
            r_retry <= 1'b0;
            r_rpend <= 1'b0;
`endif
        end else begin
            r_busy  <= w_busy;
            r_bt    <= w_bt;
            r_wr    <= w_wr;
            r_msel  <= w_msel;
            r_dup   <= w_dup;
            r_run   <= w_run;
            r_errf  <= w_errf;
            r_sync  <= w_busy && (w_bt == BT_ZERO);
            r_rd    <= w_busy && (w_bt < BT_HALF);
            r_sink  <= w_busy && (w_bt >= BT_ONE) && (w_bt <= BT_SINK_END);
            r_time  <= w_busy && (w_bt == BT_STRB);
            r_rdm   <= w_busy && (w_bt >= BT_RDM);
            r_inhbs <= w_busy && w_wr && (w_bt >= BT_HALF);
            r_done  <= w_busy && (w_bt == BT_LAST);
            r_men   <= w_men;
            r_dsel  <= w_dsel;
`ifdef MEM_TIMING_RETRY_EN
            r_retry <= w_retry;
            r_rpend <= w_rpend;
`endif
        end
    end

    assign RUN   = r_run;
    assign BUSY  = r_busy;
    assign SYNC  = r_sync;
    assign RD    = r_rd;
    assign SINK  = r_sink;
    assign TIME  = r_time;
    assign RDM   = r_rdm;
    assign INHBS = r_inhbs;
    assign DONE  = r_done;
    assign MEN   = r_men;
    assign DSEL  = r_dsel;
    assign ERRF  = r_errf;
`ifdef MEM_TIMING_RETRY_EN
    assign RETRY = r_retry;
`endif

endmodule

// File: doc/mem_timing_seq.md
Name: mem_timing_seq

Overview:
Parametrised successor to the LVDC memory timing logic. Sequences one core-memory access cycle per request: read/sink/sense-strobe/restore/inhibit windows, SYNC and DONE marks, run/halt gating, and module select across NUM_MODULES modules. Modules are arranged as duplex pairs, with parity-error failover and sticky error reporting. Sits between the instruction-timing (G/P phase) logic and the memory module drivers.

Parameters:
NUM_MODULES, 4, module count; must be even; pairs are (2k, 2k+1).
CYCLE_LEN, 14, bit times per access cycle; must be even and >= 8. HALF = CYCLE_LEN/2.
STROBE_BT, 5, bit time of the sense strobe; requires 1 <= STROBE_BT <= HALF-2.

Ports:
CLK  in  1  bit-time clock; all state changes on the rising edge.
RSTN  in  1  asynchronous active-low reset.
START  in  1  access request; sampled each edge.
WR  in  1  store access; latched with START.
MSEL  in  clog2(NUM_MODULES)  target module; latched with START.
DUPLEX  in  1  duplex mode; latched with START.
HALT  in  1  halt request.
ERRP  in  NUM_MODULES  per-module parity error; valid at STROBE_BT.
RUN  out  1  sequencer accepting requests.
BUSY  out  1  access in progress.
SYNC  out  1  high at bit time 0.
RD  out  1  read-current window.
SINK  out  1  sink-current window.
TIME  out  1  sense strobe.
RDM  out  1  read-data-mux window.
INHBS  out  1  inhibit drivers enabled (stores only).
DONE  out  1  last bit time of cycle.
MEN  out  NUM_MODULES  module drive enables.
DSEL  out  NUM_MODULES  one-hot data-source select.
ERRF  out  1  sticky memory error.

Behaviour:
- Reset (async, RSTN low): BT=0, BUSY=0, RUN=1, ERRF=0; all other outputs 0. All outputs are registered.
- Idle: START & RUN & !BUSY sampled at edge n -> BUSY=1, BT=0 in cycle n+1. WR, MSEL and DUPLEX are latched at the same edge.
- BT increments each cycle while BUSY. At BT=CYCLE_LEN-1:
  - If START & RUN is sampled, the next cycle starts at BT=0 back-to-back, with no idle gap.
  - Otherwise BUSY drops.
- START while BUSY and BT != CYCLE_LEN-1 is ignored. Requests are not queued.
- Windows while BUSY (0 when idle):
  - SYNC: BT=0.
  - RD: BT 0..HALF-1.
  - SINK: BT 1..HALF-2.
  - TIME: BT=STROBE_BT.
  - RDM: BT STROBE_BT+1..CYCLE_LEN-1.
  - INHBS: BT HALF..CYCLE_LEN-1, only when latched WR=1.
  - DONE: BT=CYCLE_LEN-1.
- MEN for the whole BUSY period:
  - Simplex: one-hot MSEL.
  - Duplex: both bits of MSEL's pair.
- DSEL defaults to one-hot MSEL at BT=0.
- Error check at the edge ending the TIME cycle. Updates are visible from BT=STROBE_BT+1.
  - Simplex: ERRP[MSEL]=1 -> ERRF=1.
  - Duplex, exactly one module of the pair in error -> DSEL switches to the good partner. ERRF is unchanged.
  - Duplex, both modules in error -> ERRF=1 and DSEL unchanged.
  - Errors on modules with MEN=0 are ignored.
- ERRF clears only on reset.
- HALT:
  - Asserted while BUSY: the current cycle completes and RUN=0 from the cycle after DONE. A back-to-back START is not accepted.
  - Asserted while idle: RUN=0 next cycle.
  - Deasserted: RUN=1 next cycle.
- Reset mid-access aborts immediately and all windows drop. This is asynchronous.

Optional Feature:
MEM_TIMING_RETRY_EN
- Defined:
  - Adds output RETRY (1 bit, reset 0).
  - A simplex parity error does not set ERRF. Instead, the access repeats once: after DONE, BT=0 with BUSY held and the same WR/MSEL, and RETRY=1 for the whole repeat.
  - An error in the repeat sets ERRF.
  - Duplex behaviour is unchanged.
  - START during the DONE cycle that precedes a retry is ignored.
  - HALT defers until the retry completes.
- Undefined: no RETRY port; behaviour as above.

Test Plan:
- Defaults, simplex read with MSEL=2 and START pulsed once -> BUSY for 14 cycles:
  - SYNC at BT0; RD at BT0-6; SINK at BT1-5; TIME at BT5; RDM at BT6-13; DONE at BT13.
  - MEN=4'b0100, INHBS=0.
- Store with WR=1, then START held high for 28 cycles -> two back-to-back cycles with no gap, and INHBS high at BT7-13 of each.
- DUPLEX=1, MSEL=0, ERRP=4'b0001 at BT5 -> MEN=4'b0011 and DSEL 0001 -> 0010 from BT6; ERRF stays 0. Repeat with ERRP=4'b0011 -> ERRF=1 and DSEL stays 0001.
- HALT raised at BT3 with START held -> cycle completes and RUN=0 after DONE with no new cycle; HALT low -> RUN=1 next cycle and an access starts the cycle after.
- RSTN low at BT9 of a store -> all outputs 0 immediately; after release, RUN=1 and ERRF=0.
- RETRY_EN, simplex, ERRP[MSEL]=1 on the first pass only -> second cycle with RETRY=1 and ERRF=0; error on both passes -> ERRF=1.
